// File: rtl/periph_bus_initiator.sv
// rtl/periph_bus_initiator.sv - peripheral-bus initiator: command stream in, in-order response stream out

// Response queue: in-order, first-word fall-through, push and pop allowed together at any occupancy.
module periph_bus_initiator_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  // A pop on an empty queue is ignored so a stray ready cannot corrupt the count.
  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array; contents are don't-care while the slot is not counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

module periph_bus_initiator #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 5,
  parameter int MASTER_ID = 0,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic                cmd_wen_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_be_i,
  output logic                req_o,
  output logic [ADDR_W-1:0]   add_o,
  output logic                wen_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [ID_W-1:0]     id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic                r_opc_i,
  input  logic [ID_W-1:0]     r_id_i,
  input  logic [DATA_W-1:0]   r_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                spurious_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int USE_W = CNT_W + 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 load;
  logic                 req;
  logic                 cmd_hs;
  logic                 gnt_hs;
  logic                 rsp_match;
  logic                 rsp_push;
  logic                 rsp_drop;
  logic                 spurious_q;
  logic [CNT_W-1:0]     outst_q;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [USE_W-1:0]     used;
  logic [DATA_W:0]      fifo_head;
  logic [ADDR_W-1:0]    add_q;
  logic                 wen_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W/8-1:0]  be_q;

  // Every slot counts once it is requested, so a granted transaction always has room for its response.
  assign used        = USE_W'(outst_q) + USE_W'(fifo_cnt) + USE_W'(state_q == REQ);
  assign cmd_ready_o = ((state_q == IDLE) | gnt_i) & (used < USE_W'(RSP_DEPTH));
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;
  assign gnt_hs      = req & gnt_i;

  assign rsp_match   = r_valid_i & (r_id_i == ID_W'(MASTER_ID));
  assign rsp_push    = rsp_match & (outst_q != '0);
  assign rsp_drop    = rsp_match & (outst_q == '0);

  assign req_o       = req;
  assign add_o       = add_q;
  assign wen_o       = wen_q;
  assign wdata_o     = wdata_q;
  assign be_o        = be_q;
  assign id_o        = ID_W'(MASTER_ID);
  assign spurious_o  = spurious_q;
  assign rsp_valid_o = (fifo_cnt != '0);
  assign rsp_rdata_o = fifo_head[DATA_W:1];
  assign rsp_err_o   = fifo_head[0];
  assign busy_o      = (state_q == REQ) | (outst_q != '0) | (fifo_cnt != '0);

  // Request FSM: load on command handshake, hold until grant, reload on a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (gnt_i) begin
          load    = cmd_hs;
          state_d = cmd_hs ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request registers, outstanding counter and spurious pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      add_q      <= '0;
      wen_q      <= 1'b1;
      wdata_q    <= '0;
      be_q       <= '0;
      outst_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      spurious_q <= rsp_drop;
      outst_q    <= outst_q + CNT_W'(gnt_hs) - CNT_W'(rsp_push);
      if (load) begin
        add_q   <= cmd_addr_i;
        wen_q   <= cmd_wen_i;
        wdata_q <= cmd_wdata_i;
        be_q    <= cmd_be_i;
      end
    end
  end

  periph_bus_initiator_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (rsp_push),
    .push_data ({r_rdata_i, r_opc_i}),
    .pop       (rsp_ready_i),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb/tb_periph_bus_initiator.sv - directed self-checking bench for periph_bus_initiator

module tb_periph_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_wen;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [4:0]  id;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [4:0]  r_id;
  logic [31:0] r_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        spurious;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  periph_bus_initiator #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .ID_W      (5),
    .MASTER_ID (3),
    .RSP_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_wen_i   (cmd_wen),
    .cmd_wdata_i (cmd_wdata),
    .cmd_be_i    (cmd_be),
    .req_o       (req),
    .add_o       (add),
    .wen_o       (wen),
    .wdata_o     (wdata),
    .be_o        (be),
    .id_o        (id),
    .gnt_i       (gnt),
    .r_valid_i   (r_valid),
    .r_opc_i     (r_opc),
    .r_id_i      (r_id),
    .r_rdata_i   (r_rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .spurious_o  (spurious),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_wen   = w;
    cmd_wdata = d;
    cmd_be    = b;
  endtask

  task automatic set_rsp(input logic v, input logic [4:0] i, input logic [31:0] d, input logic e);
    r_valid = v;
    r_id    = i;
    r_rdata = d;
    r_opc   = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt;
    int gnt_cnt;
    int spur_cnt;
    int spur_valid;

    rst_n     = 1'b0;
    gnt       = 1'b0;
    rsp_ready = 1'b0;
    set_cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    set_rsp(1'b0, 5'd0, 32'h0, 1'b0);

    // Reset state
    @(negedge clk);
    check_eq("rst_req", req, 1'b0);
    check_eq("rst_wen", wen, 1'b1);
    check_eq("rst_add", add, 32'h0);
    check_eq("rst_be", be, 4'h0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_spurious", spurious, 1'b0);
    check_eq("id", id, 5'd3);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single read with grant in the first REQ cycle
    set_cmd(1'b1, 32'h1000_0040, 1'b1, 32'h0, 4'hf);
    @(negedge clk);
    check_eq("rd_cmd_ready", cmd_ready, 1'b1);
    check_eq("rd_req_lat0", req, 1'b0);
    tick();
    cmd_valid = 1'b0;
    gnt       = 1'b1;
    @(negedge clk);
    check_eq("rd_req", req, 1'b1);
    check_eq("rd_add", add, 32'h1000_0040);
    check_eq("rd_wen", wen, 1'b1);
    tick();
    gnt = 1'b0;
    set_rsp(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_eq("rd_req_drop", req, 1'b0);
    check_eq("rd_busy_outst", busy, 1'b1);
    check_eq("rd_rsp_not_yet", rsp_valid, 1'b0);
    tick();
    r_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_rsp_valid", rsp_valid, 1'b1);
    check_eq("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_rsp_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_drained", rsp_valid, 1'b0);
    check_eq("rd_idle_busy", busy, 1'b0);

    // Stalled grant, then back-to-back issue of the next command
    set_cmd(1'b1, 32'h0000_0020, 1'b0, 32'h1111_2222, 4'h3);
    tick();
    set_cmd(1'b1, 32'h0000_0024, 1'b0, 32'h3333_4444, 4'hc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall_req_%0d", i), req, 1'b1);
      check_eq($sformatf("stall_add_%0d", i), add, 32'h0000_0020);
      check_eq($sformatf("stall_wdata_%0d", i), wdata, 32'h1111_2222);
      check_eq($sformatf("stall_be_%0d", i), be, 4'h3);
      check_eq($sformatf("stall_ready_%0d", i), cmd_ready, 1'b0);
      tick();
    end
    gnt = 1'b1;
    @(negedge clk);
    check_eq("stall_gnt_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_req", req, 1'b1);
    check_eq("b2b_add", add, 32'h0000_0024);
    check_eq("b2b_wdata", wdata, 32'h3333_4444);
    check_eq("b2b_be", be, 4'hc);
    check_eq("b2b_wen", wen, 1'b0);
    tick();
    gnt = 1'b0;

    // Foreign-id response is ignored, then two real responses (second with error)
    set_rsp(1'b1, 5'd1, 32'h0000_0099, 1'b0);
    tick();
    set_rsp(1'b1, 5'd3, 32'h0000_000A, 1'b0);
    @(negedge clk);
    check_eq("idf_no_push", rsp_valid, 1'b0);
    check_eq("idf_no_spurious", spurious, 1'b0);
    tick();
    set_rsp(1'b1, 5'd3, 32'h0000_000B, 1'b1);
    tick();
    r_valid = 1'b0;
    @(negedge clk);
    check_eq("err_spurious", spurious, 1'b0);
    check_eq("err_head_valid", rsp_valid, 1'b1);
    check_eq("err_head0_data", rsp_rdata, 32'h0000_000A);
    check_eq("err_head0_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("err_head1_data", rsp_rdata, 32'h0000_000B);
    check_eq("err_head1_err", rsp_err, 1'b1);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("err_drained", rsp_valid, 1'b0);
    check_eq("err_idle_busy", busy, 1'b0);

    // Spurious response while idle
    tick();
    set_rsp(1'b1, 5'd3, 32'h0000_0055, 1'b0);
    spur_cnt   = 0;
    spur_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (spurious) spur_cnt++;
      if (rsp_valid) spur_valid++;
      tick();
      r_valid = 1'b0;
    end
    check_eq("spur_pulses", spur_cnt, 1);
    check_eq("spur_rsp_valid", spur_valid, 0);

    // Credit limit: commands and grants always on, responses one cycle after each grant
    set_cmd(1'b1, 32'h0000_0100, 1'b1, 32'h0, 4'hf);
    gnt     = 1'b1;
    hs_cnt  = 0;
    gnt_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      set_rsp((c >= 2) && (c <= 5), 5'd3, 32'h0000_0100 + 32'(c - 2), 1'b0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) hs_cnt++;
      if (req && gnt) gnt_cnt++;
      tick();
      cmd_addr = cmd_addr + 32'h4;
    end
    r_valid = 1'b0;
    @(negedge clk);
    check_eq("credit_accepted", hs_cnt, 4);
    check_eq("credit_granted", gnt_cnt, 4);
    check_eq("credit_ready_low", cmd_ready, 1'b0);
    check_eq("credit_head", rsp_rdata, 32'h0000_0100);
    cmd_valid = 1'b0;
    gnt       = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("credit_freed", cmd_ready, 1'b1);
    check_eq("credit_next_head", rsp_rdata, 32'h0000_0101);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("drain_head2", rsp_rdata, 32'h0000_0102);
    tick();
    @(negedge clk);
    check_eq("drain_head3", rsp_rdata, 32'h0000_0103);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("drain_empty", rsp_valid, 1'b0);

    // Reset mid-flight: one buffered, two outstanding, one request pending
    tick();
    set_cmd(1'b1, 32'h0000_0200, 1'b1, 32'h0, 4'hf);
    gnt = 1'b1;
    tick();
    tick();
    set_rsp(1'b1, 5'd3, 32'h0000_0777, 1'b0);
    tick();
    r_valid = 1'b0;
    tick();
    cmd_valid = 1'b0;
    gnt       = 1'b0;
    @(negedge clk);
    check_eq("mid_req", req, 1'b1);
    check_eq("mid_buffered", rsp_valid, 1'b1);
    check_eq("mid_ready_full", cmd_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", req, 1'b0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("post_rst_ready", cmd_ready, 1'b1);
    check_eq("post_rst_wen", wen, 1'b1);
    check_eq("post_rst_add", add, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
